msx_sdram_arbiter: RTL and testbench

MSX_SDRAM_ARBITER -- requirements
Module: msx_sdram_arbiter

---
 rtl/msx_sdram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_msx_sdram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_sdram_arbiter.sv
// Arbitrates CPU cartridge reads and ioctl download writes onto a single SDRAM request port.
// Optional one-entry read cache is enabled by defining MSX_SDRAM_ARB_CACHE_EN.
module msx_sdram_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_rd,
  input  logic [24:0] cpu_addr,
  output logic        cpu_wait_n,
  output logic [7:0]  cpu_q,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        timeout_err
);

  // state   | meaning
  // IDLE    | no access outstanding, picks pending read before buffered write
  // WR_WAIT | download byte write issued, waiting for mem_ack or timeout
  // RD_WAIT | cpu read issued, waiting for mem_ack or timeout
  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        cpu_rd_q;
  logic        rd_edge;
  logic        rd_hit;
  logic        rd_pend;
  logic [24:0] rd_addr;
  logic        full;
  logic [24:0] buf_addr;
  logic [7:0]  buf_data;
  logic [7:0]  wait_cnt;
  logic        tmo;
  logic        start_rd, start_wr;
  logic        rd_done, wr_done, rd_abort, wr_abort;

  assign rd_edge    = cpu_rd && !cpu_rd_q;
  assign tmo        = (wait_cnt == TMO_LAST);
  assign ioctl_wait = full;

`ifdef MSX_SDRAM_ARB_CACHE_EN
  logic        cache_valid;
  logic [24:0] cache_tag;
  logic [7:0]  cache_data;

  assign rd_hit = cache_valid && (cache_tag == cpu_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
    end else if (rd_done) begin
      cache_valid <= 1'b1;
      cache_tag   <= mem_addr;
      cache_data  <= mem_rdata;
    end else if (wr_done && cache_valid && (cache_tag == mem_addr)) begin
      cache_valid <= 1'b0;
    end
  end
`else
  assign rd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    rd_abort  = 1'b0;
    wr_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (rd_pend) begin
          start_rd  = 1'b1;
          state_nxt = RD_WAIT;
        end else if (full) begin
          start_wr  = 1'b1;
          state_nxt = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo) begin
          rd_abort  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          wr_done   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo) begin
          wr_abort  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rd_q    <= 1'b0;
      cpu_wait_n  <= 1'b1;
      cpu_q       <= 8'hFF;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      full        <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      cpu_rd_q <= cpu_rd;

      if (start_rd) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= rd_addr;
        mem_wdata <= '0;
        wait_cnt  <= '0;
      end else if (start_wr) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= buf_addr;
        mem_wdata <= buf_data;
        wait_cnt  <= '0;
      end else if (rd_done || wr_done || rd_abort || wr_abort) begin
        mem_req <= 1'b0;
      end else if (state != IDLE) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (rd_done) begin
        cpu_q      <= mem_rdata;
        rd_pend    <= 1'b0;
        cpu_wait_n <= 1'b1;
      end
      if (rd_abort) begin
        cpu_q      <= 8'hFF;
        rd_pend    <= 1'b0;
        cpu_wait_n <= 1'b1;
      end
      if (wr_done || wr_abort) full <= 1'b0;
      if (rd_abort || wr_abort) timeout_err <= 1'b1;

      // full here is the pre-edge value, so a strobe in the completion cycle is still dropped
      if (ioctl_wr && !full) begin
        buf_addr <= ioctl_addr;
        buf_data <= ioctl_dout;
        full     <= 1'b1;
      end

      if (rd_edge) begin
        if (rd_hit) begin
`ifdef MSX_SDRAM_ARB_CACHE_EN
          cpu_q <= cache_data;
`endif
        end else begin
          rd_pend    <= 1'b1;
          rd_addr    <= cpu_addr;
          cpu_wait_n <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_msx_sdram_arbiter.sv
// Self-checking bench for msx_sdram_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed cycle counts and data.
module tb_msx_sdram_arbiter;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic        cpu_wait_n;
  logic [7:0]  cpu_q;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        timeout_err;

  msx_sdram_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_wait_n(cpu_wait_n), .cpu_q(cpu_q),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // SDRAM responder: ack in the ack_lat-th cycle of a request (0 = never answer)
  int         ack_lat = 0;
  int         req_age = 0;
  logic [7:0] rd_data_cfg = 8'h00;

  always @(posedge clk) begin
    #1;
    if (ack_lat != 0) begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        req_age = 0;
      end else if (mem_req) begin
        req_age++;
        if (req_age == ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_data_cfg;
        end
      end else begin
        req_age = 0;
      end
    end else begin
      req_age = 0;
    end
  end

  // Transaction-level reference model
  logic        m_prev_rd, m_rd_pend, m_full, m_wait_n, m_req, m_we, m_err;
  logic [24:0] m_rd_addr, m_buf_addr, m_addr;
  logic [7:0]  m_buf_data, m_q, m_wdata;
  int          m_busy, m_age;   // m_busy: 0 none, 1 read, 2 write
  logic        c_valid;
  logic [24:0] c_tag;
  logic [7:0]  c_data;

  always @(posedge clk or negedge reset_n) begin : mdl
    logic edge_rd, old_full, old_pend, hit;
    logic [7:0] hit_data;
    if (!reset_n) begin
      m_prev_rd = 0; m_rd_pend = 0; m_full = 0; m_wait_n = 1; m_req = 0; m_we = 0; m_err = 0;
      m_rd_addr = 0; m_buf_addr = 0; m_addr = 0; m_buf_data = 0; m_q = 8'hFF; m_wdata = 0;
      m_busy = 0; m_age = 0; c_valid = 0; c_tag = 0; c_data = 0;
    end else begin
      edge_rd  = cpu_rd && !m_prev_rd;
      m_prev_rd = cpu_rd;
      old_full = m_full;
      old_pend = m_rd_pend;
`ifdef MSX_SDRAM_ARB_CACHE_EN
      hit = c_valid && (c_tag == cpu_addr);
`else
      hit = 1'b0;
`endif
      hit_data = c_data;
      if (m_busy != 0) begin
        if (mem_ack) begin
          if (m_busy == 1) begin
            m_q = mem_rdata; m_rd_pend = 0; m_wait_n = 1;
            c_valid = 1; c_tag = m_addr; c_data = mem_rdata;
          end else begin
            m_full = 0;
            if (c_valid && c_tag == m_addr) c_valid = 0;
          end
          m_busy = 0; m_req = 0;
        end else if (m_age == TMO) begin
          if (m_busy == 1) begin
            m_q = 8'hFF; m_rd_pend = 0; m_wait_n = 1;
          end else begin
            m_full = 0;
          end
          m_err = 1; m_busy = 0; m_req = 0;
        end else begin
          m_age++;
        end
      end else if (old_pend) begin
        m_busy = 1; m_age = 1; m_req = 1; m_we = 0; m_addr = m_rd_addr; m_wdata = 0;
      end else if (old_full) begin
        m_busy = 2; m_age = 1; m_req = 1; m_we = 1; m_addr = m_buf_addr; m_wdata = m_buf_data;
      end
      if (ioctl_wr && !old_full) begin
        m_buf_addr = ioctl_addr; m_buf_data = ioctl_dout; m_full = 1;
      end
      if (edge_rd) begin
        if (hit) m_q = hit_data;
        else begin
          m_rd_pend = 1; m_rd_addr = cpu_addr; m_wait_n = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cpu_wait_n", cpu_wait_n, m_wait_n);
    chk("cpu_q", cpu_q, m_q);
    chk("ioctl_wait", ioctl_wait, m_full);
    chk("mem_req", mem_req, m_req);
    chk("timeout_err", timeout_err, m_err);
    if (m_req) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // Scenario monitors
  int          n_req_rise, cnt_req_high, cnt_wait_low, wait_fall, cnt_iow_high;
  logic        prev_req = 0, prev_wait_n = 1;
  logic        rec_we [4];
  logic [24:0] rec_addr [4];
  logic [7:0]  rec_wdata [4];

  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      if (n_req_rise < 4) begin
        rec_we[n_req_rise]    = mem_we;
        rec_addr[n_req_rise]  = mem_addr;
        rec_wdata[n_req_rise] = mem_wdata;
      end
      n_req_rise++;
    end
    if (mem_req) cnt_req_high++;
    if (!cpu_wait_n) cnt_wait_low++;
    if (!cpu_wait_n && prev_wait_n) wait_fall++;
    if (ioctl_wait) cnt_iow_high++;
    prev_req    = mem_req;
    prev_wait_n = cpu_wait_n;
  end

  task automatic clear_counts();
    n_req_rise = 0; cnt_req_high = 0; cnt_wait_low = 0; wait_fall = 0; cnt_iow_high = 0;
    for (int i = 0; i < 4; i++) begin
      rec_we[i] = 1'bx; rec_addr[i] = 'x; rec_wdata[i] = 'x;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    step(1);
    ioctl_wr = 1'b0;
  endtask

  initial begin
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wait_n", cpu_wait_n, 1'b1);
    chk("rst_q", cpu_q, 8'hFF);
    chk("rst_iowait", ioctl_wait, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 25'h0);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_err", timeout_err, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(2);

    // single read, ack in 5th request cycle
    ack_lat = 5; rd_data_cfg = 8'h3C; clear_counts();
    cpu_addr = 25'h000100; cpu_rd = 1'b1;
    step(15);
    cpu_rd = 1'b0; step(2);
    chk("a_wait_low", cnt_wait_low, 6);
    chk("a_req_high", cnt_req_high, 5);
    chk("a_nreq", n_req_rise, 1);
    chk("a_addr", rec_addr[0], 25'h000100);
    chk("a_q", cpu_q, 8'h3C);

    // two download strobes one cycle apart: second dropped
    ack_lat = 4; clear_counts();
    wr_byte(25'h0012345, 8'h5A);
    step(1);
    wr_byte(25'h0000777, 8'h99);
    step(12);
    chk("b_nreq", n_req_rise, 1);
    chk("b_we", rec_we[0], 1'b1);
    chk("b_addr", rec_addr[0], 25'h0012345);
    chk("b_wdata", rec_wdata[0], 8'h5A);
    chk("b_iow_high", cnt_iow_high, 5);

    // read edge while the write is in flight
    ack_lat = 4; clear_counts();
    wr_byte(25'h0000200, 8'h11);
    step(1);
    cpu_addr = 25'h0000300; rd_data_cfg = 8'h77; cpu_rd = 1'b1;
    step(15);
    cpu_rd = 1'b0; step(2);
    chk("c_nreq", n_req_rise, 2);
    chk("c_we0", rec_we[0], 1'b1);
    chk("c_we1", rec_we[1], 1'b0);
    chk("c_addr1", rec_addr[1], 25'h0000300);
    chk("c_wait_fall", wait_fall, 1);
    chk("c_wait_low", cnt_wait_low, 8);
    chk("c_q", cpu_q, 8'h77);

    // read timeout
    ack_lat = 0; clear_counts();
    cpu_addr = 25'h0000555; cpu_rd = 1'b1;
    step(20);
    cpu_rd = 1'b0; step(2);
    chk("d_req_high", cnt_req_high, TMO);
    chk("d_wait_low", cnt_wait_low, 9);
    chk("d_q", cpu_q, 8'hFF);
    chk("d_err", timeout_err, 1'b1);

    ack_lat = 2; rd_data_cfg = 8'h42; clear_counts();
    cpu_addr = 25'h0000556; cpu_rd = 1'b1;
    step(8);
    cpu_rd = 1'b0; step(2);
    chk("d2_q", cpu_q, 8'h42);
    chk("d2_req_high", cnt_req_high, 2);
    chk("d2_err_sticky", timeout_err, 1'b1);

    // write timeout discards the byte
    ack_lat = 0; clear_counts();
    wr_byte(25'h0000900, 8'h33);
    step(15);
    chk("e_nreq", n_req_rise, 1);
    chk("e_req_high", cnt_req_high, TMO);
    chk("e_iow_high", cnt_iow_high, 9);
    chk("e_iowait", ioctl_wait, 1'b0);

    // reset in the middle of a read, then a stray ack
    ack_lat = 0;
    cpu_addr = 25'h0001000; cpu_rd = 1'b1;
    step(4);
    chk("f_req_before", mem_req, 1'b1);
    chk("f_wait_before", cpu_wait_n, 1'b0);
    reset_n = 1'b0; cpu_rd = 1'b0;
    #1;
    chk("f_req_async", mem_req, 1'b0);
    chk("f_wait_async", cpu_wait_n, 1'b1);
    chk("f_err_async", timeout_err, 1'b0);
    step(2);
    reset_n = 1'b1;
    step(1);
    mem_rdata = 8'h12; mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    step(2);
    chk("f_q_late_ack", cpu_q, 8'hFF);
    chk("f_req_late_ack", mem_req, 1'b0);

`ifdef MSX_SDRAM_ARB_CACHE_EN
    ack_lat = 3; rd_data_cfg = 8'hC4; clear_counts();
    cpu_addr = 25'h0004000; cpu_rd = 1'b1;
    step(10);
    cpu_rd = 1'b0; step(2);
    chk("g_fill_q", cpu_q, 8'hC4);
    chk("g_fill_nreq", n_req_rise, 1);

    rd_data_cfg = 8'hD0; clear_counts();
    cpu_rd = 1'b1;
    step(4);
    cpu_rd = 1'b0; step(2);
    chk("g_hit_nreq", n_req_rise, 0);
    chk("g_hit_wait", cnt_wait_low, 0);
    chk("g_hit_q", cpu_q, 8'hC4);

    clear_counts();
    wr_byte(25'h0004000, 8'h05);
    step(8);
    rd_data_cfg = 8'hE1;
    cpu_rd = 1'b1;
    step(10);
    cpu_rd = 1'b0; step(2);
    chk("g_inv_nreq", n_req_rise, 2);
    chk("g_inv_we1", rec_we[1], 1'b0);
    chk("g_inv_q", cpu_q, 8'hE1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
